div_seq: RTL and testbench

Iterative RV32M divide/remainder sequencer that borrows the EXU's shared ALU, not a private subtractor. It handles DIV, DIVU, REM and REMU with a restoring, 1-bit-per-cycle algorithm, using the ALU adder in unsigned subtract mode for each trial subtraction and for sign negations. It sits beside the ALU in the EXU, and the EXU's ALU input mux selects this block whenever `alu_req` is granted.

---
 rtl/div_seq_if.sv | 39 +++
 rtl/div_seq.sv | 205 ++++++++++++++++++++
 tb/tb_div_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_seq_if.sv
// Bus between the EXU and the div_seq divide sequencer: request/response
// handshake plus the shared-ALU borrow port. master = EXU side, slave = div_seq.
interface div_seq_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        alu_req;
  logic        alu_gnt;
  logic [2:0]  alu_sel;
  logic        alu_add_sub;
  logic        alu_s_u;
  logic        alu_a_l;
  logic        alu_l_r;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_less;
  logic        alu_is_zero;

  modport master (
    output flush, in_valid, op, src1, src2, out_ready,
           alu_gnt, alu_result, alu_less, alu_is_zero,
    input  in_ready, out_valid, out_result,
           alu_req, alu_sel, alu_add_sub, alu_s_u, alu_a_l, alu_l_r, alu_a, alu_b
  );

  modport slave (
    input  flush, in_valid, op, src1, src2, out_ready,
           alu_gnt, alu_result, alu_less, alu_is_zero,
    output in_ready, out_valid, out_result,
           alu_req, alu_sel, alu_add_sub, alu_s_u, alu_a_l, alu_l_r, alu_a, alu_b
  );
endinterface

// File: rtl/div_seq.sv
// RV32M DIV/DIVU/REM/REMU restoring divider, 1 bit per cycle, borrowing the EXU ALU
// for every subtraction. Define DIV_SKIP_EN to add an early-out compare (CMP) state.
module div_seq (
  input  logic       i_clk,
  input  logic       i_rst,
  div_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_NEGA, S_NEGB, S_ITER, S_FIX, S_DONE
`ifdef DIV_SKIP_EN
    , S_CMP
`endif
  } state_t;

`ifdef DIV_SKIP_EN
  localparam state_t S_CORE = S_CMP;
`else
  localparam state_t S_CORE = S_ITER;
`endif

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_rem;
  logic        r_na;
  logic        r_nb;
  logic [31:0] r_q;
  logic [31:0] r_r;
  logic [31:0] r_b;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_out_result;

  logic        w_in_sgn;
  logic        w_in_na;
  logic        w_in_nb;
  logic        w_alu_req;
  logic        w_gnt;
  logic        w_hi;
  logic [31:0] w_shift_r;
  logic        w_take;
  logic [31:0] w_fix_val;
  logic        w_fix_neg;
  logic [31:0] w_alu_a;
  logic [31:0] w_alu_b;
  logic        w_unused;

  assign w_unused  = bus.alu_is_zero;

  assign w_in_sgn  = ~bus.op[0];
  assign w_in_na   = w_in_sgn & bus.src1[31];
  assign w_in_nb   = w_in_sgn & bus.src2[31];

  assign w_alu_req = (r_state == S_NEGA) || (r_state == S_NEGB) ||
`ifdef DIV_SKIP_EN
                     (r_state == S_CMP) ||
`endif
                     (r_state == S_ITER) || (r_state == S_FIX);
  assign w_gnt     = w_alu_req & bus.alu_gnt;

  // hi is the bit shifted out of R; when set the 33-bit partial remainder
  // is certainly >= divisor, so the ALU's 32-bit difference is exact.
  assign w_hi      = r_r[31];
  assign w_shift_r = {r_r[30:0], r_q[31]};
  assign w_take    = w_hi | ~bus.alu_less;

  assign w_fix_val = r_rem ? r_r : r_q;
  assign w_fix_neg = r_rem ? r_na : (r_na ^ r_nb);

  always_comb begin
    w_alu_a = '0;
    w_alu_b = '0;
    case (r_state)
      S_NEGA: w_alu_b = r_q;
      S_NEGB: w_alu_b = r_b;
`ifdef DIV_SKIP_EN
      S_CMP: begin
        w_alu_a = r_q;
        w_alu_b = r_b;
      end
`endif
      S_ITER: begin
        w_alu_a = w_shift_r;
        w_alu_b = r_b;
      end
      S_FIX:  w_alu_b = w_fix_val;
      default: begin
        w_alu_a = '0;
        w_alu_b = '0;
      end
    endcase
  end

  assign bus.alu_req     = w_alu_req;
  assign bus.alu_sel     = 3'b000;
  assign bus.alu_add_sub = w_alu_req;
  assign bus.alu_s_u     = w_alu_req;
  assign bus.alu_a_l     = 1'b0;
  assign bus.alu_l_r     = 1'b0;
  assign bus.alu_a       = w_alu_a;
  assign bus.alu_b       = w_alu_b;
  assign bus.in_ready    = r_in_ready;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_result  = r_out_result;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_rem        <= 1'b0;
      r_na         <= 1'b0;
      r_nb         <= 1'b0;
      r_q          <= '0;
      r_r          <= '0;
      r_b          <= '0;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
    end else if (bus.flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_rem      <= bus.op[1];
            r_na       <= w_in_na;
            r_nb       <= w_in_nb;
            r_q        <= bus.src1;
            r_r        <= '0;
            r_b        <= bus.src2;
            r_cnt      <= 5'd31;
            r_in_ready <= 1'b0;
            if (bus.src2 == 32'd0) begin
              r_out_result <= bus.op[1] ? bus.src1 : 32'hFFFF_FFFF;
              r_out_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else if (w_in_sgn && bus.src1 == 32'h8000_0000 &&
                         bus.src2 == 32'hFFFF_FFFF) begin
              r_out_result <= bus.op[1] ? 32'd0 : 32'h8000_0000;
              r_out_valid  <= 1'b1;
              r_state      <= S_DONE;
            end else if (w_in_na) begin
              r_state <= S_NEGA;
            end else if (w_in_nb) begin
              r_state <= S_NEGB;
            end else begin
              r_state <= S_CORE;
            end
          end
        end
        S_NEGA: begin
          if (w_gnt) begin
            r_q     <= bus.alu_result;
            r_state <= r_nb ? S_NEGB : S_CORE;
          end
        end
        S_NEGB: begin
          if (w_gnt) begin
            r_b     <= bus.alu_result;
            r_state <= S_CORE;
          end
        end
`ifdef DIV_SKIP_EN
        S_CMP: begin
          if (w_gnt) begin
            if (bus.alu_less) begin
              r_r     <= r_q;
              r_q     <= '0;
              r_state <= S_FIX;
            end else begin
              r_state <= S_ITER;
            end
          end
        end
`endif
        S_ITER: begin
          if (w_gnt) begin
            r_r <= w_take ? bus.alu_result : w_shift_r;
            r_q <= {r_q[30:0], w_take};
            if (r_cnt == 5'd0) r_state <= S_FIX;
            else               r_cnt   <= r_cnt - 5'd1;
          end
        end
        S_FIX: begin
          if (w_gnt) begin
            r_out_result <= w_fix_neg ? bus.alu_result : w_fix_val;
            r_out_valid  <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: ALU model, arithmetic reference model with a
// per-cycle compare process, and literal expected results/latencies per vector.
module tb_div_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  div_seq_if u_if ();
  div_seq dut (.i_clk(clk), .i_rst(rst), .bus(u_if.slave));

  // Shared ALU: subtract when routed to the divider, unrelated junk otherwise.
  logic [31:0] junk;
  logic        junk_b;
  always @(posedge clk) begin
    junk   <= $urandom;
    junk_b <= $urandom_range(0, 1);
  end
  assign u_if.alu_result  = u_if.alu_gnt ? (u_if.alu_a - u_if.alu_b) : junk;
  assign u_if.alu_less    = u_if.alu_gnt ? (u_if.alu_a < u_if.alu_b) : junk_b;
  assign u_if.alu_is_zero = (u_if.alu_result == 32'd0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic sgn = !op[0];
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
    if (sgn) return op[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return op[1] ? a % b : a / b;
  endfunction

  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic sgn = !op[0];
    int n;
    logic [31:0] ma, mb;
    if (b == 0) return 1;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    n  = int'(sgn & a[31]) + int'(sgn & b[31]);
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
`ifdef DIV_SKIP_EN
    if (ma < mb) return 3 + n;
    return 35 + n;
`else
    if (ma < mb) return 34 + n;
    return 34 + n;
`endif
  endfunction

  // Scoreboard shared between the driver and the compare process.
  logic        exp_pending = 1'b0;
  logic        exp_active  = 1'b0;
  logic [31:0] exp_res     = '0;
  int          exp_cyc     = 0;

  initial begin
    logic        prev_stall;
    logic [63:0] prev_ab;
    prev_stall = 1'b0;
    prev_ab    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (u_if.alu_req) begin
          chk("alu_ctl", {u_if.alu_sel, u_if.alu_add_sub, u_if.alu_s_u, u_if.alu_a_l, u_if.alu_l_r},
              7'b000_1_1_0_0);
          if (prev_stall) chk("alu_frozen", {u_if.alu_a, u_if.alu_b}, prev_ab);
        end else begin
          chk("alu_idle", {u_if.alu_sel, u_if.alu_add_sub, u_if.alu_s_u, u_if.alu_a_l,
                           u_if.alu_l_r, u_if.alu_a, u_if.alu_b}, 64'd0);
        end
        prev_stall = u_if.alu_req && !u_if.alu_gnt && !u_if.flush;
        prev_ab    = {u_if.alu_a, u_if.alu_b};
        if (u_if.out_valid) begin
          if (!exp_active) begin
            checks++;
            errors++;
            $display("FAIL unexpected_valid: got out_valid=1 want 0 (cycle %0d)", cyc);
          end else begin
            chk("model_result", u_if.out_result, exp_res);
            chk("in_ready_busy", u_if.in_ready, 0);
            if (exp_pending) begin
              chk("model_latency", cyc, exp_cyc);
              exp_pending = 1'b0;
            end
            if (u_if.out_ready) exp_active = 1'b0;
          end
        end else if (exp_pending && cyc > exp_cyc + 4) begin
          checks++;
          errors++;
          $display("FAIL model_timeout: got no out_valid want valid at cycle %0d", exp_cyc);
          exp_pending = 1'b0;
          exp_active  = 1'b0;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
    int          lat_skip;
    int          stall_s;
    int          stall_k;
    int          hold;
    int          flush_at;
  } vec_t;

  vec_t vecs[$];

  task automatic run(input vec_t v);
    int T, vcyc;
    logic done;
    @(posedge clk); #1;
    chk("in_ready_idle", u_if.in_ready, 1);
    T = cyc;
    u_if.in_valid  = 1'b1;
    u_if.op        = v.op;
    u_if.src1      = v.a;
    u_if.src2      = v.b;
    u_if.out_ready = (v.hold < 0);
    exp_res     = ref_res(v.op, v.a, v.b);
    exp_cyc     = T + ref_lat(v.op, v.a, v.b) + v.stall_k;
    exp_pending = 1'b1;
    exp_active  = 1'b1;
    vcyc = -1;
    done = 1'b0;
    for (int i = 0; i < 90 && !done; i++) begin
      @(posedge clk); #1;
      u_if.in_valid = 1'b0;
      u_if.alu_gnt  = !(v.stall_k > 0 && cyc >= T + v.stall_s && cyc < T + v.stall_s + v.stall_k);
      if (v.flush_at > 0 && cyc == T + v.flush_at) begin
        u_if.flush  = 1'b1;
        exp_pending = 1'b0;
        exp_active  = 1'b0;
      end else if (v.flush_at > 0 && cyc == T + v.flush_at + 1) begin
        u_if.flush = 1'b0;
        chk("flush_in_ready", u_if.in_ready, 1);
        chk("flush_no_valid", u_if.out_valid, 0);
        done = 1'b1;
      end
      if (v.flush_at == 0) begin
        if (u_if.out_valid && vcyc < 0) begin
          vcyc = cyc;
          chk("lit_result", u_if.out_result, v.res);
`ifdef DIV_SKIP_EN
          chk("lit_latency", cyc - T, v.lat_skip);
`else
          chk("lit_latency", cyc - T, v.lat);
`endif
        end
        if (vcyc >= 0) begin
          if (!u_if.out_valid) done = 1'b1;
          else u_if.out_ready = (cyc - vcyc >= v.hold);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drv_timeout: got no completion want done (op %0d a %0h b %0h)", v.op, v.a, v.b);
    end
    u_if.out_ready = 1'b0;
    u_if.flush     = 1'b0;
    u_if.alu_gnt   = 1'b1;
    exp_pending    = 1'b0;
    exp_active     = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] res, input int lat, input int lat_skip,
                              input int stall_s = 0, input int stall_k = 0,
                              input int hold = 0, input int flush_at = 0);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.res = res; v.lat = lat; v.lat_skip = lat_skip;
    v.stall_s = stall_s; v.stall_k = stall_k; v.hold = hold; v.flush_at = flush_at;
    return v;
  endfunction

  initial begin
    u_if.flush     = 1'b0;
    u_if.in_valid  = 1'b0;
    u_if.op        = 2'b00;
    u_if.src1      = '0;
    u_if.src2      = '0;
    u_if.out_ready = 1'b0;
    u_if.alu_gnt   = 1'b1;

    vecs.push_back(mk(2'b01, 32'd100, 32'd7, 32'd14, 34, 35));
    vecs.push_back(mk(2'b11, 32'd100, 32'd7, 32'd2, 34, 35));
    vecs.push_back(mk(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 35, 36));
    vecs.push_back(mk(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 35, 36));
    vecs.push_back(mk(2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 36, 37));
    vecs.push_back(mk(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1));
    vecs.push_back(mk(2'b10, 32'd5, 32'd0, 32'd5, 1, 1));
    vecs.push_back(mk(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1));
    vecs.push_back(mk(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1));
    vecs.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 37, 38, 5, 3));
    vecs.push_back(mk(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 37, 38, 1, 2));
    vecs.push_back(mk(2'b01, 32'd3, 32'd10, 32'd0, 34, 3));
    vecs.push_back(mk(2'b11, 32'd3, 32'd10, 32'd3, 34, 3));
    vecs.push_back(mk(2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, 35, 36));
    vecs.push_back(mk(2'b10, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 35, 36));
    vecs.push_back(mk(2'b00, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 35, 36));
    vecs.push_back(mk(2'b01, 32'h1234_5678, 32'h100, 32'h0012_3456, 34, 35, 0, 0, 5));
    vecs.push_back(mk(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, 35, 0, 0, -1));
    vecs.push_back(mk(2'b01, 32'd0, 32'd5, 32'd0, 34, 3));
    vecs.push_back(mk(2'b11, 32'd7, 32'hFFFF_FFFF, 32'd7, 34, 3));
    vecs.push_back(mk(2'b01, 32'd100, 32'd7, 32'd14, 34, 35, 0, 0, 0, 10));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready",   u_if.in_ready, 1);
    chk("rst_out_valid",  u_if.out_valid, 0);
    chk("rst_out_result", u_if.out_result, 0);
    chk("rst_alu_req",    u_if.alu_req, 0);
    chk("rst_alu_ab",     {u_if.alu_a, u_if.alu_b}, 64'd0);

    foreach (vecs[i]) run(vecs[i]);

    // Flush wins over a request in the same IDLE cycle.
    @(posedge clk); #1;
    u_if.flush    = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.op       = 2'b01;
    u_if.src1     = 32'd9;
    u_if.src2     = 32'd3;
    @(posedge clk); #1;
    u_if.flush    = 1'b0;
    u_if.in_valid = 1'b0;
    chk("flush_vs_accept", u_if.in_ready, 1);
    repeat (3) @(posedge clk);
    #1 chk("flush_vs_accept_idle", {u_if.in_ready, u_if.alu_req}, 2'b10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
